// File: rtl/usb_redir_tx_fifo.sv
// Byte FIFO from a core-side transmitter to the SPI user_io block.
// The user_io ack (strobe_out) is asynchronous and is edge-detected after a synchroniser.
module usb_redir_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_strobe,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            data_out,
    output logic                  data_out_available,
    input  logic                  strobe_out
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    logic [7:0]          r_mem [DEPTH];
    ptr_t                r_wr_ptr;
    ptr_t                r_rd_ptr;
    logic [DEPTH_LOG2:0] r_level;
    logic                r_full;
    logic                r_avail;
    logic                r_overflow;
    logic [7:0]          r_data_out;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;

    logic                w_pop_req;
    logic                w_push;
    logic                w_pop;
    ptr_t                w_rd_ptr_inc;
    logic [DEPTH_LOG2:0] w_level_nxt;

    // Rising edge of the synchronised ack; the chain resets high so a strobe
    // already asserted at reset release never looks like an edge.
    assign w_pop_req    = r_s2 & ~r_s3;
    assign w_push       = wr_strobe & ~r_full;
    assign w_pop        = w_pop_req & r_avail;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= strobe_out;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_avail    <= 1'b0;
            r_overflow <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end

            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LEVEL_FULL);
            r_avail <= (w_level_nxt != '0);

            if (wr_strobe && r_full) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end

            // Head changes only on a pop or a push into an empty FIFO; with one entry
            // left, a concurrent push becomes the new head before it reaches memory.
            if (w_push && !r_avail) begin
                r_data_out <= wr_data;
            end else if (w_pop && r_level != LEVEL_ONE) begin
                r_data_out <= r_mem[w_rd_ptr_inc];
            end else if (w_pop && w_push) begin
                r_data_out <= wr_data;
            end
        end
    end

    assign full               = r_full;
    assign overflow           = r_overflow;
    assign level              = r_level;
    assign data_out           = r_data_out;
    assign data_out_available = r_avail;

endmodule

// File: tb/tb_usb_redir_tx_fifo.sv
// Self-checking bench for usb_redir_tx_fifo: cycle model plus push-order scoreboard.
module tb_usb_redir_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                wr_strobe = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                overflow_clr = 1'b0;
    logic                strobe_out = 1'b0;
    logic                full;
    logic                overflow;
    logic [DEPTH_LOG2:0] level;
    logic [7:0]          data_out;
    logic                data_out_available;

    int errors = 0;
    int checks = 0;

    // Reference model state, updated once per clock edge inside step().
    logic [7:0] m_q [$];
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_s3 = 1'b1;
    logic       m_ovf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    bit         m_popped;
    bit         m_pushed;
    logic [7:0] m_pop_byte;
    logic [7:0] prev_dout;

    usb_redir_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .wr_strobe          (wr_strobe),
        .wr_data            (wr_data),
        .full               (full),
        .overflow           (overflow),
        .overflow_clr       (overflow_clr),
        .level              (level),
        .data_out           (data_out),
        .data_out_available (data_out_available),
        .strobe_out         (strobe_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input logic rst_n_i, input logic wr_i, input logic [7:0] d_i,
                        input logic stb_i, input logic clr_i);
        logic pop_req;
        logic push_ok;
        reset_n      = rst_n_i;
        wr_strobe    = wr_i;
        wr_data      = d_i;
        strobe_out   = stb_i;
        overflow_clr = clr_i;
        prev_dout    = data_out;
        @(posedge clk);
        m_popped = 1'b0;
        m_pushed = 1'b0;
        if (!rst_n_i) begin
            m_q.delete();
            m_s1   = 1'b1;
            m_s2   = 1'b1;
            m_s3   = 1'b1;
            m_ovf  = 1'b0;
            m_dout = 8'h00;
        end else begin
            pop_req = m_s2 & ~m_s3;
            push_ok = wr_i && (m_q.size() < DEPTH);
            if (wr_i && m_q.size() == DEPTH) m_ovf = 1'b1;
            else if (clr_i) m_ovf = 1'b0;
            if (pop_req && m_q.size() != 0) begin
                m_pop_byte = m_q.pop_front();
                m_popped   = 1'b1;
            end
            if (push_ok) begin
                m_q.push_back(d_i);
                m_pushed = 1'b1;
            end
            if (m_q.size() != 0) m_dout = m_q[0];
            m_s3 = m_s2;
            m_s2 = m_s1;
            m_s1 = stb_i;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic stb);
        repeat (n) step(1'b1, 1'b0, 8'h00, stb, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic ack_pulse();
        idle(4, 1'b1);
        idle(4, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (data_out_available !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b expected 0", data_out_available); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    endtask

    task automatic test_basic();
        do_reset();
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        idle(1, 1'b0);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL basic_level: got %0d expected 3", level); end
        checks++; if (data_out_available !== 1'b1) begin errors++; $display("FAIL basic_avail: got %b expected 1", data_out_available); end
        checks++; if (data_out !== 8'hA1) begin errors++; $display("FAIL basic_head0: got %h expected a1", data_out); end
        ack_pulse();
        checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL basic_head1: got %h expected b2", data_out); end
        ack_pulse();
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL basic_head2: got %h expected c3", data_out); end
        ack_pulse();
        checks++; if (data_out_available !== 1'b0) begin errors++; $display("FAIL basic_empty_avail: got %b expected 0", data_out_available); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_empty_level: got %0d expected 0", level); end
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL basic_hold: got %h expected c3", data_out); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            push_byte(8'(i));
            if (i == DEPTH - 1) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, data_out, 8'(i)); end
            ack_pulse();
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", level); end
    endtask

    task automatic test_push_pop_same_cycle();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i));
        idle(2, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL pp_full_level: got %0d expected 15", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pp_full_overflow: got %b expected 1", overflow); end
        checks++; if (data_out !== 8'h21) begin errors++; $display("FAIL pp_full_head: got %h expected 21", data_out); end
        idle(1, 1'b1);
        idle(4, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (data_out !== 8'(8'h20 + i)) begin errors++; $display("FAIL pp_drain%0d: got %h expected %h", i, data_out, 8'(8'h20 + i)); end
            ack_pulse();
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL pp_drained: got %0d expected 0", level); end

        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
        idle(2, 1'b1);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL pp_mid_level: got %0d expected 5", level); end
        checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL pp_mid_head: got %h expected 41", data_out); end
        idle(1, 1'b1);
        idle(4, 1'b0);
    endtask

    task automatic test_strobe_hold();
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h60 + i));
        idle(20, 1'b1);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL hold_level: got %0d expected 3", level); end
        checks++; if (data_out !== 8'h61) begin errors++; $display("FAIL hold_head: got %h expected 61", data_out); end
        idle(4, 1'b0);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL hold_fall: got %0d expected 3", level); end
        repeat (3) ack_pulse();
        ack_pulse();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL underflow_level: got %0d expected 0", level); end
        checks++; if (data_out_available !== 1'b0) begin errors++; $display("FAIL underflow_avail: got %b expected 0", data_out_available); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL underflow_full: got %b expected 0", full); end
    endtask

    task automatic test_reset_strobe_high();
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 1'b1, 8'h7E, 1'b1, 1'b0);
        idle(3, 1'b1);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL rsthi_level: got %0d expected 1", level); end
        checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL rsthi_data: got %h expected 7e", data_out); end
        checks++; if (data_out_available !== 1'b1) begin errors++; $display("FAIL rsthi_avail: got %b expected 1", data_out_available); end
        idle(4, 1'b0);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL rsthi_fall: got %0d expected 1", level); end
        ack_pulse();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rsthi_pop: got %0d expected 0", level); end
    endtask

    task automatic test_stream();
        logic [7:0] sb_q [$];
        logic [7:0] exp;
        logic [7:0] d;
        logic       wr;
        logic       stb;
        int         n_pushed;
        int         n_popped;
        int         hold;
        int         cycles;
        do_reset();
        n_pushed = 0;
        n_popped = 0;
        stb      = 1'b0;
        hold     = 4;
        cycles   = 0;
        while ((n_pushed < 40 || m_q.size() != 0) && cycles < 5000) begin
            wr = (n_pushed < 40) && (m_q.size() < DEPTH) && ($urandom_range(0, 2) == 0);
            d  = 8'($urandom_range(0, 255));
            step(1'b1, wr, d, stb, 1'b0);
            cycles++;
            if (m_pushed) begin
                sb_q.push_back(d);
                n_pushed++;
            end
            if (m_popped) begin
                exp = sb_q.pop_front();
                n_popped++;
                checks++; if (prev_dout !== exp) begin errors++; $display("FAIL stream_pop%0d: got %h expected %h", n_popped, prev_dout, exp); end
            end
            checks++; if (level !== 5'(m_q.size())) begin errors++; $display("FAIL stream_level@%0d: got %0d expected %0d", cycles, level, m_q.size()); end
            hold--;
            if (hold == 0) begin
                stb  = ~stb;
                hold = $urandom_range(3, 6);
            end
        end
        checks++; if (n_popped != 40) begin errors++; $display("FAIL stream_count: got %0d expected 40 (cycles %0d)", n_popped, cycles); end
        idle(4, 1'b0);

        for (int i = 0; i < 6; i++) push_byte(8'(8'hD0 + i));
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", level); end
        checks++; if (data_out_available !== 1'b0) begin errors++; $display("FAIL midrst_avail: got %b expected 0", data_out_available); end
        idle(4, 1'b0);
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL midrst_release: got %0d expected 0", level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_same_cycle();
        test_strobe_hold();
        test_reset_strobe_high();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
